// File: rtl/kbd_pico_fifo.sv
// Keyboard-to-PicoBlaze bridge: captures decoded scan codes, translates them to
// command codes, buffers them in a small FIFO and exposes it on the I/O bus.
module kbd_pico_fifo #(
   parameter int unsigned DEPTH_LOG2  = 2,
   parameter logic [7:0]  PORT_STATUS = 8'h0A,
   parameter logic [7:0]  PORT_DATA   = 8'h0B
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] letra,
   input  logic       new_data,
   output logic       new_data_pico,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   output logic       overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT_LOW} state_t;

   state_t                r_state, w_next;
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr, r_rd;
   logic [CW-1:0]         r_count;
   logic                  r_overflow, r_interrupt, r_armed, r_new_data_pico;

   logic [7:0] w_code;
   logic       w_capture, w_valid, w_empty, w_full, w_pop, w_push, w_drop, w_stat_rd;

   // Scan code to command code; zero marks an ignored key
   always_comb begin
      w_code = 8'h00;
      case (letra)
         8'h2B:   w_code = 8'h01;
         8'h33:   w_code = 8'h02;
         8'h2C:   w_code = 8'h03;
         8'h75:   w_code = 8'h04;
         8'h72:   w_code = 8'h05;
         8'h6B:   w_code = 8'h06;
         8'h74:   w_code = 8'h07;
         8'h76:   w_code = 8'h08;
         default: w_code = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // WAIT_LOW keeps a late-clearing decoder flag from producing a second push
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (new_data) begin
               w_capture = 1'b1;
               w_next    = ST_ACK;
            end
         end
         ST_ACK:      w_next = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!new_data) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   assign w_empty   = (r_count == CW'(0));
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_valid   = (w_code != 8'h00);
   assign w_pop     = read_strobe && (port_id == PORT_DATA) && !w_empty;
   assign w_push    = w_capture && w_valid && (!w_full || w_pop);
   assign w_drop    = w_capture && w_valid && w_full && !w_pop;
   assign w_stat_rd = read_strobe && (port_id == PORT_STATUS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_code;
            r_wr        <= r_wr + DEPTH_LOG2'(1);
         end
         if (w_pop) r_rd <= r_rd + DEPTH_LOG2'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   // Acknowledge, sticky overflow and interrupt/arming
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_new_data_pico <= 1'b0;
         r_overflow      <= 1'b0;
         r_interrupt     <= 1'b0;
         r_armed         <= 1'b1;
      end else begin
         r_new_data_pico <= (w_next == ST_ACK) && (r_state == ST_IDLE);
         if (w_drop)         r_overflow <= 1'b1;
         else if (w_stat_rd) r_overflow <= 1'b0;
         if (interrupt_ack) begin
            r_interrupt <= 1'b0;
            r_armed     <= 1'b0;
         end else begin
            r_interrupt <= r_armed && !w_empty;
            if (w_empty) r_armed <= 1'b1;
         end
      end
   end

   always_comb begin
      in_port = 8'h00;
      if (port_id == PORT_DATA)
         in_port = w_empty ? 8'h00 : r_mem[r_rd];
      else if (port_id == PORT_STATUS)
         in_port = {r_overflow, w_full, w_empty, 1'b0, 4'(r_count)};
   end

   assign new_data_pico = r_new_data_pico;
   assign interrupt     = r_interrupt;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_kbd_pico_fifo.sv
// Directed bench for kbd_pico_fifo: translation table plus multi-cycle corner sequences.
module tb_kbd_pico_fifo;

   localparam logic [7:0] P_STAT = 8'h0A;
   localparam logic [7:0] P_DATA = 8'h0B;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] letra;
   logic       new_data;
   logic       new_data_pico;
   logic [7:0] port_id;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   logic       overflow;

   int n_vec = 0;
   int n_err = 0;

   kbd_pico_fifo #(.DEPTH_LOG2(2), .PORT_STATUS(P_STAT), .PORT_DATA(P_DATA)) dut (
      .clk           (clk),
      .reset         (reset),
      .letra         (letra),
      .new_data      (new_data),
      .new_data_pico (new_data_pico),
      .port_id       (port_id),
      .read_strobe   (read_strobe),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] letra;
      logic [7:0] code;
      logic [7:0] status;
      logic       irq;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Decoder raises new_data, holds it until the acknowledge, then drops it
   task automatic send_key(input logic [7:0] code);
      letra    = code;
      new_data = 1'b1;
      @(negedge clk);
      chk("ack_pulse", 8'(new_data_pico), 8'h01);
      new_data = 1'b0;
      @(negedge clk);
      chk("ack_single", 8'(new_data_pico), 8'h00);
      @(negedge clk);
   endtask

   task automatic read_data(input logic [7:0] exp);
      port_id     = P_DATA;
      read_strobe = 1'b1;
      #1;
      chk("data_read", in_port, exp);
      @(negedge clk);
      read_strobe = 1'b0;
      port_id     = P_STAT;
   endtask

   task automatic chk_status(input string name, input logic [7:0] exp);
      port_id = P_STAT;
      #1;
      chk(name, in_port, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      tbl[0]  = '{8'h2B, 8'h01, 8'h01, 1'b1};
      tbl[1]  = '{8'h1C, 8'h00, 8'h20, 1'b0};
      tbl[2]  = '{8'h33, 8'h02, 8'h01, 1'b1};
      tbl[3]  = '{8'h2C, 8'h03, 8'h01, 1'b1};
      tbl[4]  = '{8'h00, 8'h00, 8'h20, 1'b0};
      tbl[5]  = '{8'h75, 8'h04, 8'h01, 1'b1};
      tbl[6]  = '{8'h72, 8'h05, 8'h01, 1'b1};
      tbl[7]  = '{8'h6B, 8'h06, 8'h01, 1'b1};
      tbl[8]  = '{8'hFF, 8'h00, 8'h20, 1'b0};
      tbl[9]  = '{8'h74, 8'h07, 8'h01, 1'b1};
      tbl[10] = '{8'h76, 8'h08, 8'h01, 1'b1};

      reset = 1'b1; letra = 8'h00; new_data = 1'b0; port_id = 8'h00;
      read_strobe = 1'b0; interrupt_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      chk_status("rst_status", 8'h20);
      chk("rst_irq", 8'(interrupt), 8'h00);
      chk("rst_ack", 8'(new_data_pico), 8'h00);
      chk("rst_ovf", 8'(overflow), 8'h00);
      port_id = 8'h55; #1;
      chk("other_port", in_port, 8'h00);

      // Translation table: push, status, interrupt, pop
      for (int i = 0; i < 11; i++) begin
         send_key(tbl[i].letra);
         chk_status("tbl_status", tbl[i].status);
         chk("tbl_irq", 8'(interrupt), 8'(tbl[i].irq));
         if (tbl[i].code != 8'h00) begin
            read_data(tbl[i].code);
            chk_status("tbl_drained", 8'h20);
         end
      end

      // Pop when empty is ignored
      port_id = P_DATA; read_strobe = 1'b1; #1;
      chk("empty_data", in_port, 8'h00);
      @(negedge clk);
      read_strobe = 1'b0;
      chk_status("empty_pop", 8'h20);

      // Overflow: five keys into a four-deep FIFO
      send_key(8'h75); send_key(8'h72); send_key(8'h6B); send_key(8'h74); send_key(8'h76);
      chk_status("full_status", 8'hC4);
      chk("ovf_flag", 8'(overflow), 8'h01);
      read_data(8'h04); read_data(8'h05); read_data(8'h06); read_data(8'h07);
      chk_status("ovf_held", 8'hA0);
      read_strobe = 1'b1; #1;
      chk("ovf_preclear", in_port, 8'hA0);
      @(negedge clk);
      read_strobe = 1'b0;
      chk_status("ovf_cleared", 8'h20);

      // Simultaneous push and pop with three entries, write pointer wrapping
      send_key(8'h2B); send_key(8'h33); send_key(8'h2C);
      chk_status("three_status", 8'h03);
      letra = 8'h74; new_data = 1'b1; port_id = P_DATA; read_strobe = 1'b1; #1;
      chk("simul_head", in_port, 8'h01);
      @(negedge clk);
      read_strobe = 1'b0;
      chk("simul_ack", 8'(new_data_pico), 8'h01);
      new_data = 1'b0;
      chk_status("simul_count", 8'h03);
      @(negedge clk); @(negedge clk);
      read_data(8'h02); read_data(8'h03); read_data(8'h07);
      chk_status("simul_drained", 8'h20);

      // Interrupt acknowledge disarms until the FIFO drains
      send_key(8'h2B);
      chk("irq_raise", 8'(interrupt), 8'h01);
      interrupt_ack = 1'b1;
      @(negedge clk);
      interrupt_ack = 1'b0;
      chk("irq_acked", 8'(interrupt), 8'h00);
      send_key(8'h2C);
      chk("irq_disarmed", 8'(interrupt), 8'h00);
      repeat (3) @(negedge clk);
      chk("irq_still_low", 8'(interrupt), 8'h00);
      read_data(8'h01); read_data(8'h03);
      chk_status("irq_drained", 8'h20);
      send_key(8'h33);
      chk("irq_rearmed", 8'(interrupt), 8'h01);
      read_data(8'h02);

      // new_data held long after the acknowledge
      letra = 8'h6B; new_data = 1'b1; pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (new_data_pico) pulses++;
      end
      new_data = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("held_pulses", 8'(pulses), 8'h01);
      chk_status("held_count", 8'h01);
      send_key(8'h76);
      chk_status("two_count", 8'h02);

      // Asynchronous reset mid-operation
      #2;
      reset = 1'b1;
      #1;
      chk_status("midrst_status", 8'h20);
      chk("midrst_irq", 8'(interrupt), 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_status("postrst_status", 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
